sprite_renderer: RTL and testbench

Parametrised, pipelined sprite pixel generator for the pong display path. It sits between the VGA timing generator and the colour mux and answers "does the sprite cover this pixel?" for a sprite of configurable size, integer scale and shape. Sprite position, shape and enable are latched once per frame so the image never tears. A per-frame collision flag is also produced against a background/paddle mask.

---
 rtl/sprite_pkg.sv | 34 +++
 rtl/sprite_shape_rom.sv | 34 +++
 rtl/sprite_renderer.sv | 173 +++++++++++++++++
 tb/tb_sprite_renderer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite renderer:
//   SHAPE_ROUND / SHAPE_SQUARE : encoding of the shape select bit
//   disc_bit(size, r, c)       : 1 when cell (r, c) of a size x size grid lies
//                                inside the inscribed disc
// -----------------------------------------------------------------------------
package sprite_pkg;

  localparam logic SHAPE_ROUND  = 1'b0;
  localparam logic SHAPE_SQUARE = 1'b1;

  // Cell (r, c) is on iff (2r+1-size)^2 + (2c+1-size)^2 <= size^2.
  // The signed offsets are folded into unsigned absolute distances so that
  // all arithmetic stays unsigned.
  function automatic logic disc_bit(input logic [6:0] size,
                                    input logic [5:0] r,
                                    input logic [5:0] c);
    logic [6:0]  odd_r;
    logic [6:0]  odd_c;
    logic [6:0]  dist_r;
    logic [6:0]  dist_c;
    logic [13:0] sum_sq;
    logic [13:0] lim_sq;
    odd_r  = {r, 1'b1};
    odd_c  = {c, 1'b1};
    dist_r = (odd_r >= size) ? (odd_r - size) : (size - odd_r);
    dist_c = (odd_c >= size) ? (odd_c - size) : (size - odd_c);
    sum_sq = (14'(dist_r) * 14'(dist_r)) + (14'(dist_c) * 14'(dist_c));
    lim_sq = 14'(size) * 14'(size);
    return (sum_sq <= lim_sq);
  endfunction

endpackage

// File: rtl/sprite_shape_rom.sv
// -----------------------------------------------------------------------------
// sprite_shape_rom
// Combinational cell lookup for a SIZE x SIZE sprite.
//   shape_i   : SHAPE_ROUND or SHAPE_SQUARE
//   row_i     : cell row, 0 = top
//   col_i     : cell column, 0 = leftmost
//   cell_on_o : the addressed cell is part of the sprite
// The disc table is built from constants at elaboration, so it folds into
// plain LUT logic.
// -----------------------------------------------------------------------------
module sprite_shape_rom
  import sprite_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic                    shape_i,
  input  logic [$clog2(SIZE)-1:0] row_i,
  input  logic [$clog2(SIZE)-1:0] col_i,
  output logic                    cell_on_o
);

  // Entry index is row*SIZE + col, i.e. the concatenation {row, col}.
  logic [SIZE*SIZE-1:0] disc_tbl;

  genvar gi;
  generate
    for (gi = 0; gi < SIZE * SIZE; gi++) begin : g_disc
      assign disc_tbl[gi] = disc_bit(7'(SIZE), 6'(gi / SIZE), 6'(gi % SIZE));
    end
  endgenerate

  assign cell_on_o = (shape_i == SHAPE_ROUND) ? disc_tbl[{row_i, col_i}] : 1'b1;

endmodule

// File: rtl/sprite_renderer.sv
// -----------------------------------------------------------------------------
// sprite_renderer
// Two-stage pipelined "is this pixel covered by the sprite" generator with a
// per-frame collision flag.
//   clk, rst_n                   : pixel clock, async active-low reset
//   frame_start                  : frame pulse; latches pos/shape/enable and
//                                  publishes the collision of the closed frame
//   pos_x_in, pos_y_in           : sprite top-left (latched on frame_start)
//   shape_sel, enable_in         : shape and visibility (latched on frame_start)
//   pix_valid, pix_x, pix_y      : current pixel
//   bg_on                        : background object covers current pixel
//   pix_on, pix_on_valid         : result for the pixel from two cycles ago
//   collision                    : previous frame had a sprite/background hit
// -----------------------------------------------------------------------------
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int SCALE_LOG2 = 0,
  parameter int X_W        = 10,
  parameter int Y_W        = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_start,
  input  logic [X_W-1:0] pos_x_in,
  input  logic [Y_W-1:0] pos_y_in,
  input  logic           shape_sel,
  input  logic           enable_in,
  input  logic           pix_valid,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  input  logic           bg_on,
  output logic           pix_on,
  output logic           pix_on_valid,
  output logic           collision
);

  localparam int AW = $clog2(SIZE);
  // On-screen sprite extent in pixels, at the width of the difference.
  localparam logic [X_W:0] EXT_X = (X_W+1)'(SIZE << SCALE_LOG2);
  localparam logic [Y_W:0] EXT_Y = (Y_W+1)'(SIZE << SCALE_LOG2);

  // ---------------- shadow registers ----------------
  logic [X_W-1:0] sx_q;
  logic [Y_W-1:0] sy_q;
  logic           sshape_q;
  logic           sen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q     <= '0;
      sy_q     <= '0;
      sshape_q <= SHAPE_ROUND;
      sen_q    <= 1'b0;
    end else if (frame_start) begin
      sx_q     <= pos_x_in;
      sy_q     <= pos_y_in;
      sshape_q <= shape_sel;
      sen_q    <= enable_in;
    end
  end

  // ---------------- stage 1: offset, bounds, cell address ----------------
  logic [X_W:0]    dx;
  logic [Y_W:0]    dy;
  logic            inside_d;
  logic [AW-1:0]   col_d;
  logic [AW-1:0]   row_d;

  // MSB of each difference is the borrow: pixel left of / above the sprite.
  assign dx       = {1'b0, pix_x} - {1'b0, sx_q};
  assign dy       = {1'b0, pix_y} - {1'b0, sy_q};
  assign inside_d = ~dx[X_W] & ~dy[Y_W] & (dx < EXT_X) & (dy < EXT_Y);
  assign col_d    = dx[SCALE_LOG2 +: AW];
  assign row_d    = dy[SCALE_LOG2 +: AW];

  logic          valid1_q;
  logic          inside1_q;
  logic          bg1_q;
  logic [AW-1:0] col1_q;
  logic [AW-1:0] row1_q;
  logic          shape1_q;
  logic          en1_q;

  // Shape and enable travel with the pixel so a pixel coinciding with
  // frame_start is rendered entirely with the old frame's settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_q  <= 1'b0;
      inside1_q <= 1'b0;
      bg1_q     <= 1'b0;
      col1_q    <= '0;
      row1_q    <= '0;
      shape1_q  <= SHAPE_ROUND;
      en1_q     <= 1'b0;
    end else begin
      valid1_q  <= pix_valid;
      inside1_q <= inside_d;
      bg1_q     <= bg_on;
      col1_q    <= col_d;
      row1_q    <= row_d;
      shape1_q  <= sshape_q;
      en1_q     <= sen_q;
    end
  end

  // ---------------- stage 2: shape lookup ----------------
  logic cell_on;
  logic pix_on_d;

  sprite_shape_rom #(
    .SIZE(SIZE)
  ) u_shape_rom (
    .shape_i   (shape1_q),
    .row_i     (row1_q),
    .col_i     (col1_q),
    .cell_on_o (cell_on)
  );

  assign pix_on_d = valid1_q & inside1_q & en1_q & cell_on;

  logic pix_on_q;
  logic pix_on_valid_q;
  logic bg2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_on_q       <= 1'b0;
      pix_on_valid_q <= 1'b0;
      bg2_q          <= 1'b0;
    end else begin
      pix_on_q       <= pix_on_d;
      pix_on_valid_q <= valid1_q;
      bg2_q          <= bg1_q & valid1_q;
    end
  end

  // ---------------- collision accumulator ----------------
  logic hit;
  logic acc_q;
  logic acc_d;
  logic collision_q;
  logic collision_d;

  assign hit = pix_on_q & bg2_q;

  // A hit sitting in stage 2 on the frame_start edge belongs to the frame
  // being closed, hence it is OR-ed into the published flag.
  always_comb begin
    acc_d       = acc_q | hit;
    collision_d = collision_q;
    if (frame_start) begin
      collision_d = acc_q | hit;
      acc_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      collision_q <= collision_d;
    end
  end

  assign pix_on       = pix_on_q;
  assign pix_on_valid = pix_on_valid_q;
  assign collision    = collision_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_sprite_renderer
// Drives a SCALE_LOG2=0 and a SCALE_LOG2=1 instance (SIZE 8, 10-bit coords)
// with the same stimulus and compares both against a geometric reference
// model of the sprite, its frame latching and the collision flag.
// -----------------------------------------------------------------------------
module tb_sprite_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic [9:0] pos_x_in;
  logic [9:0] pos_y_in;
  logic       shape_sel;
  logic       enable_in;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       bg_on;
  logic       pix_on0, pix_on_valid0, collision0;
  logic       pix_on1, pix_on_valid1, collision1;

  always #5 clk = ~clk;

  sprite_renderer #(.SIZE(8), .SCALE_LOG2(0), .X_W(10), .Y_W(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .shape_sel(shape_sel),
    .enable_in(enable_in), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .bg_on(bg_on), .pix_on(pix_on0),
    .pix_on_valid(pix_on_valid0), .collision(collision0)
  );

  sprite_renderer #(.SIZE(8), .SCALE_LOG2(1), .X_W(10), .Y_W(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .shape_sel(shape_sel),
    .enable_in(enable_in), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .bg_on(bg_on), .pix_on(pix_on1),
    .pix_on_valid(pix_on_valid1), .collision(collision1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_sx, m_sy;
  bit m_shape, m_en;
  bit m_acc0, m_acc1, m_col0, m_col1;
  // index 0: result of the pixel driven last cycle, index 1: visible on outputs
  bit p_v[2], p_on0[2], p_on1[2], p_bg[2];

  // Geometric definition: the sprite covers an (8<<s)-pixel square starting at
  // (sx, sy) with no wrap; round cells lie inside the inscribed disc.
  function automatic bit ref_on(int px, int py, int s);
    int dx, dy, r, c;
    if (!m_en) return 1'b0;
    if (px < m_sx || py < m_sy) return 1'b0;
    dx = px - m_sx;
    dy = py - m_sy;
    if (dx >= (8 << s) || dy >= (8 << s)) return 1'b0;
    if (m_shape) return 1'b1;
    r = dy >> s;
    c = dx >> s;
    return ((2*r + 1 - 8) * (2*r + 1 - 8) + (2*c + 1 - 8) * (2*c + 1 - 8)) <= 64;
  endfunction

  task automatic model_clear();
    m_sx = 0; m_sy = 0; m_shape = 1'b0; m_en = 1'b0;
    m_acc0 = 1'b0; m_acc1 = 1'b0; m_col0 = 1'b0; m_col1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 1'b0; p_on0[i] = 1'b0; p_on1[i] = 1'b0; p_bg[i] = 1'b0;
    end
  endtask

  // One clock: drive a pixel (and optionally frame_start), advance the model,
  // then check every output of both instances.
  task automatic step(input bit fs, input int x, input int y, input bit bg, input bit pv);
    bit n_on0, n_on1, hit0, hit1;
    frame_start = fs;
    pix_x = 10'(x);
    pix_y = 10'(y);
    bg_on = bg;
    pix_valid = pv;
    n_on0 = pv && ref_on(x, y, 0);
    n_on1 = pv && ref_on(x, y, 1);
    hit0 = p_on0[1] && p_bg[1];
    hit1 = p_on1[1] && p_bg[1];
    if (fs) begin
      m_col0 = m_acc0 | hit0; m_acc0 = 1'b0;
      m_col1 = m_acc1 | hit1; m_acc1 = 1'b0;
      m_sx = int'(pos_x_in); m_sy = int'(pos_y_in);
      m_shape = shape_sel; m_en = enable_in;
    end else begin
      m_acc0 = m_acc0 | hit0;
      m_acc1 = m_acc1 | hit1;
    end
    @(posedge clk);
    #1;
    p_v[1] = p_v[0]; p_on0[1] = p_on0[0]; p_on1[1] = p_on1[0]; p_bg[1] = p_bg[0];
    p_v[0] = pv; p_on0[0] = n_on0; p_on1[0] = n_on1; p_bg[0] = bg;
    check_eq("valid_s0", 32'(pix_on_valid0), 32'(p_v[1]));
    check_eq("valid_s1", 32'(pix_on_valid1), 32'(p_v[1]));
    check_eq("pix_on_s0", 32'(pix_on0), 32'(p_on0[1]));
    check_eq("pix_on_s1", 32'(pix_on1), 32'(p_on1[1]));
    check_eq("coll_s0", 32'(collision0), 32'(m_col0));
    check_eq("coll_s1", 32'(collision1), 32'(m_col1));
    $display("[TB] fs=%0b v=%0b x=%0d y=%0d bg=%0b | on0=%0b on1=%0b ov=%0b col0=%0b col1=%0b",
             fs, pv, x, y, bg, pix_on0, pix_on1, pix_on_valid0, collision0, collision1);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic new_frame();
    step(1'b1, 0, 0, 1'b0, 1'b0);
  endtask

  // Drive one pixel, let it reach the output, and compare with hand-derived values.
  task automatic probe(input string tag, input int x, input int y, input bit e0, input bit e1);
    step(1'b0, x, y, 1'b0, 1'b1);
    idle();
    check_eq({tag, "_s0"}, 32'(pix_on0), 32'(e0));
    check_eq({tag, "_s1"}, 32'(pix_on1), 32'(e1));
    check_eq({tag, "_ov"}, 32'(pix_on_valid0), 32'd1);
  endtask

  task automatic set_sprite(input int x, input int y, input bit shp, input bit en);
    pos_x_in = 10'(x); pos_y_in = 10'(y); shape_sel = shp; enable_in = en;
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; bg_on = 1'b0;
    set_sprite(0, 0, 1'b0, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pix_on", 32'(pix_on0 | pix_on1), 32'd0);
    check_eq("rst_valid", 32'(pix_on_valid0 | pix_on_valid1), 32'd0);
    check_eq("rst_coll", 32'(collision0 | collision1), 32'd0);
    rst_n = 1'b1;

    // Round sprite at (100, 50)
    set_sprite(100, 50, 1'b0, 1'b1);
    new_frame();
    probe("r_101_50", 101, 50, 1'b0, 1'b0);
    probe("r_102_50", 102, 50, 1'b1, 1'b0);
    probe("r_105_50", 105, 50, 1'b1, 1'b1);
    probe("r_106_50", 106, 50, 1'b0, 1'b1);
    probe("r_99_53", 99, 53, 1'b0, 1'b0);
    probe("r_100_53", 100, 53, 1'b1, 1'b0);
    // Scaling points
    probe("s_103_50", 103, 50, 1'b1, 1'b0);
    probe("s_104_50", 104, 50, 1'b1, 1'b1);
    probe("s_115_57", 115, 57, 1'b0, 1'b1);
    probe("s_116_57", 116, 57, 1'b0, 1'b0);
    probe("s_100_66", 100, 66, 1'b0, 1'b0);

    // Shadowing: position input moves without frame_start
    pos_x_in = 10'd200;
    probe("sh_hold", 102, 50, 1'b1, 1'b0);
    new_frame();
    probe("sh_moved", 102, 50, 1'b0, 1'b0);

    // Collision: overlap at (104, 54), published on the next frame_start
    set_sprite(100, 50, 1'b0, 1'b1);
    new_frame();
    step(1'b0, 104, 54, 1'b1, 1'b1);
    idle(); idle();
    check_eq("coll_pending", 32'(collision0 | collision1), 32'd0);
    new_frame();
    check_eq("coll_set_s0", 32'(collision0), 32'd1);
    check_eq("coll_set_s1", 32'(collision1), 32'd1);
    step(1'b0, 104, 54, 1'b0, 1'b1);
    step(1'b0, 300, 54, 1'b1, 1'b1);
    idle(); idle();
    new_frame();
    check_eq("coll_clr", 32'(collision0 | collision1), 32'd0);

    // Hit again, then reset mid-frame while pix_on and collision are high
    step(1'b0, 104, 54, 1'b1, 1'b1);
    idle(); idle();
    new_frame();
    step(1'b0, 100, 53, 1'b0, 1'b1);
    idle();
    check_eq("pre_rst_on", 32'(pix_on0), 32'd1);
    check_eq("pre_rst_coll", 32'(collision0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_on", 32'(pix_on0 | pix_on1), 32'd0);
    check_eq("async_rst_valid", 32'(pix_on_valid0 | pix_on_valid1), 32'd0);
    check_eq("async_rst_coll", 32'(collision0 | collision1), 32'd0);
    model_clear();
    pix_valid = 1'b1; pix_x = 10'd104; pix_y = 10'd54;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_hold_valid", 32'(pix_on_valid0 | pix_on_valid1), 32'd0);
    idle(); idle();

    // Square shape corner
    set_sprite(100, 50, 1'b1, 1'b1);
    new_frame();
    probe("sq_corner", 100, 50, 1'b1, 1'b1);

    // Disabled sprite: never on, never collides
    set_sprite(100, 50, 1'b1, 1'b0);
    new_frame();
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 96 + int'($urandom_range(0, 24)), 46 + int'($urandom_range(0, 24)), 1'b1, 1'b1);
      check_eq("dis_on", 32'(pix_on0 | pix_on1), 32'd0);
    end
    idle(); idle();
    new_frame();
    check_eq("dis_coll", 32'(collision0 | collision1), 32'd0);

    // Randomised frames, including positions near the screen edges
    for (int i = 0; i < 500; i++) begin
      bit fs;
      int ox, oy;
      fs = ($urandom_range(0, 39) == 0);
      if (fs) begin
        set_sprite(($urandom_range(0, 3) == 0) ? int'($urandom_range(1008, 1023)) : int'($urandom_range(0, 1023)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 1023)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
      end
      ox = int'($urandom_range(0, 24)) - 4;
      oy = int'($urandom_range(0, 24)) - 4;
      step(fs, (m_sx + ox) & 1023, (m_sy + oy) & 1023,
           1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
